// File: rtl/ball_draw_ctrl.sv
// Ball render sequencer: requests clear-old / draw-new (or score black-screen),
// waits for renderer done strobes, then releases a single physics move_tick.
module ball_draw_ctrl #(
    parameter int unsigned PAUSE_FRAMES = 15,
    parameter int unsigned TIMEOUT      = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frameTick,
    input  logic       lhs_scored,
    input  logic       rhs_scored,
    input  logic       done_clearOld,
    input  logic       done_drawNew,
    input  logic       done_blackScreen,
    output logic       clearOld_pulse,
    output logic       drawNew_pulse,
    output logic       blackScreen_pulse,
    output logic       plot,
    output logic       move_tick,
    output logic       busy,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned PC_W = $clog2(PAUSE_FRAMES) + 1;
    localparam int unsigned OV_W = 8;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_CLEAR = 3'd2,
        S_DRAW  = 3'd3,
        S_BLACK = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              score_pend_q, score_pend_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [PC_W-1:0]   pause_q, pause_d;
    logic [OV_W-1:0]   overrun_q, overrun_d;
    logic              timeout_err_q, timeout_err_d;
    logic              move_tick_q, move_tick_d;
    logic              clr_q, clr_d;
    logic              drw_q, drw_d;
    logic              blk_q, blk_d;
    logic              plot_q, plot_d;
    logic              busy_q, busy_d;

    logic              in_phase;
    logic              expired;
    logic              drop;

    // Next-state, watchdog, counters and registered-output decode
    always_comb begin
        state_d       = state_q;
        score_pend_d  = score_pend_q;
        wdog_d        = '0;
        pause_d       = pause_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        move_tick_d   = 1'b0;

        in_phase = (state_q == S_INIT) || (state_q == S_CLEAR) ||
                   (state_q == S_DRAW) || (state_q == S_BLACK);
        expired  = in_phase && (wdog_q == WD_W'(TIMEOUT - 1));

        unique case (state_q)
            S_INIT: begin
                if (done_blackScreen) begin
                    state_d = S_IDLE;
                end else if (expired) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (frameTick && enable) begin
                    if (score_pend_q) begin
                        state_d      = S_BLACK;
                        score_pend_d = 1'b0;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (done_clearOld) begin
                    state_d = S_DRAW;
                end else if (expired) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_DRAW: begin
                if (done_drawNew) begin
                    state_d     = S_IDLE;
                    move_tick_d = 1'b1;
                end else if (expired) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_BLACK: begin
                if (done_blackScreen) begin
                    state_d = S_PAUSE;
                    pause_d = '0;
                end else if (expired) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (frameTick) begin
                    if (pause_q == PC_W'(PAUSE_FRAMES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        pause_d = pause_q + PC_W'(1);
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // A score seen on the S_BLACK entry edge re-arms rather than being lost
        if (lhs_scored || rhs_scored) begin
            score_pend_d = 1'b1;
        end

        if (in_phase && (state_d == state_q)) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        drop = frameTick && (in_phase || ((state_q == S_IDLE) && !enable));
        if (drop && (overrun_q != {OV_W{1'b1}})) begin
            overrun_d = overrun_q + OV_W'(1);
        end

        clr_d  = (state_d == S_CLEAR);
        drw_d  = (state_d == S_DRAW);
        blk_d  = (state_d == S_INIT) || (state_d == S_BLACK);
        plot_d = clr_d || drw_d || blk_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT;
            score_pend_q  <= 1'b0;
            wdog_q        <= '0;
            pause_q       <= '0;
            overrun_q     <= '0;
            timeout_err_q <= 1'b0;
            move_tick_q   <= 1'b0;
            clr_q         <= 1'b0;
            drw_q         <= 1'b0;
            blk_q         <= 1'b0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_pend_q  <= score_pend_d;
            wdog_q        <= wdog_d;
            pause_q       <= pause_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            move_tick_q   <= move_tick_d;
            clr_q         <= clr_d;
            drw_q         <= drw_d;
            blk_q         <= blk_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
        end
    end

    assign clearOld_pulse    = clr_q;
    assign drawNew_pulse     = drw_q;
    assign blackScreen_pulse = blk_q;
    assign plot              = plot_q;
    assign move_tick         = move_tick_q;
    assign busy              = busy_q;
    assign overrun_cnt       = overrun_q;
    assign timeout_err       = timeout_err_q;

endmodule
